// File: rtl/mod_counter_if.sv
// Bus bundle for mod_counter: the control strobes, load data and the count
// outputs. The controller side uses the master modport and the counter uses
// the slave modport.
interface mod_counter_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             at_bound;

  modport master (
    output en,
    output up,
    output load,
    output load_val,
    input  out,
    input  tc,
    input  at_bound
  );

  modport slave (
    input  en,
    input  up,
    input  load,
    input  load_val,
    output out,
    output tc,
    output at_bound
  );

endinterface

// File: rtl/mod_counter.sv
// Up/down modulo counter with a terminal value of MAX_VAL.
// MODE 0 wraps at either end of 0..MAX_VAL. MODE 1 saturates at either end.
// The count and the terminal-count pulse are registered.
// at_bound is decoded combinationally from the count and the current direction.
// A load takes priority over counting, and the load value is clamped to MAX_VAL.
module mod_counter #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int unsigned      MODE    = 32'd0
) (
  input logic           clk,
  input logic           reset,
  mod_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic             SATURATE = (MODE == 32'd1);

  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic [WIDTH-1:0] next_count_s;
  logic             next_tc_s;
  logic             at_bound_s;

  // Load values above the terminal count are pulled down to MAX_VAL.
  // This keeps the count inside 0..MAX_VAL.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
    logic [WIDTH-1:0] result;
    if (value > MAX_VAL) begin
      result = MAX_VAL;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // Next count and terminal-count flag. The priority order is load, then en, then hold.
  always_comb begin
    next_count_s = count_r;
    next_tc_s    = 1'b0;
    if (bus.load) begin
      next_count_s = clamp_load(bus.load_val);
      next_tc_s    = 1'b0;
    end else if (bus.en) begin
      if (bus.up) begin
        // Counting up. The >= test also pulls a corrupted count back into range.
        if (count_r >= MAX_VAL) begin
          if (SATURATE) begin
            next_count_s = MAX_VAL;
            next_tc_s    = 1'b0;
          end else begin
            next_count_s = ZERO;
            next_tc_s    = 1'b1;
          end
        end else begin
          next_count_s = count_r + ONE;
          // In saturate mode, flag the step that lands on the top bound.
          next_tc_s    = SATURATE && (count_r == (MAX_VAL - ONE));
        end
      end else begin
        // Counting down.
        if (count_r == ZERO) begin
          if (SATURATE) begin
            next_count_s = ZERO;
            next_tc_s    = 1'b0;
          end else begin
            next_count_s = MAX_VAL;
            next_tc_s    = 1'b1;
          end
        end else begin
          next_count_s = count_r - ONE;
          // In saturate mode, flag the step that lands on zero.
          next_tc_s    = SATURATE && (count_r == ONE);
        end
      end
    end else begin
      next_count_s = count_r;
      next_tc_s    = 1'b0;
    end
  end

  // State register. The asynchronous reset clears the count and the pulse immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= ZERO;
      tc_r    <= 1'b0;
    end else begin
      count_r <= next_count_s;
      tc_r    <= next_tc_s;
    end
  end

  // The bound depends on the direction: MAX_VAL when counting up, 0 when counting down.
  always_comb begin
    at_bound_s = 1'b0;
    if (bus.up) begin
      at_bound_s = (count_r == MAX_VAL);
    end else begin
      at_bound_s = (count_r == ZERO);
    end
  end

  assign bus.out      = count_r;
  assign bus.tc       = tc_r;
  assign bus.at_bound = at_bound_s;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter.
// It runs three instances: 4-bit modulo 10 wrapping, 4-bit modulo 10 saturating,
// and 8-bit modulo 256 wrapping.
// An arithmetic reference model is checked on every falling clock edge.
// Directed literal expectations pin the model.
module tb_mod_counter;

  logic clk;
  logic reset;

  mod_counter_if #(.WIDTH(4)) if0 ();
  mod_counter_if #(.WIDTH(4)) if1 ();
  mod_counter_if #(.WIDTH(8)) if2 ();

  mod_counter #(.WIDTH(4), .MAX_VAL(4'd9),   .MODE(32'd0)) u0 (.clk(clk), .reset(reset), .bus(if0));
  mod_counter #(.WIDTH(4), .MAX_VAL(4'd9),   .MODE(32'd1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  mod_counter #(.WIDTH(8), .MAX_VAL(8'd255), .MODE(32'd0)) u2 (.clk(clk), .reset(reset), .bus(if2));

  int checks = 0;
  int errors = 0;

  int maxv [3] = '{9, 9, 255};
  int mode [3] = '{0, 1, 0};
  int exp_out [3] = '{0, 0, 0};
  int exp_tc  [3] = '{0, 0, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference step: move by +/-1 within 0..maxv. Leaving the range wraps (mode 0) or holds (mode 1).
  task automatic model_step(input int k, input logic en, input logic up, input logic load, input int lv);
    int cand;
    if (load) begin
      exp_out[k] = (lv > maxv[k]) ? maxv[k] : lv;
      exp_tc[k]  = 0;
    end else if (en) begin
      cand = exp_out[k] + (up ? 1 : -1);
      if (cand < 0 || cand > maxv[k]) begin
        if (mode[k] == 0) begin
          exp_out[k] = (cand < 0) ? maxv[k] : 0;
          exp_tc[k]  = 1;
        end else begin
          exp_tc[k]  = 0;
        end
      end else begin
        exp_out[k] = cand;
        exp_tc[k]  = (mode[k] == 1 && cand == (up ? maxv[k] : 0)) ? 1 : 0;
      end
    end else begin
      exp_tc[k] = 0;
    end
  endtask

  // Reference model state update.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        exp_out[k] = 0;
        exp_tc[k]  = 0;
      end
    end else begin
      model_step(0, if0.en, if0.up, if0.load, int'(if0.load_val));
      model_step(1, if1.en, if1.up, if1.load, int'(if1.load_val));
      model_step(2, if2.en, if2.up, if2.load, int'(if2.load_val));
    end
  end

  // Compare process: check all three instances against the model away from the active edge.
  always @(negedge clk) begin
    check("u0.out", 32'(if0.out), 32'(exp_out[0]));
    check("u0.tc",  32'(if0.tc),  32'(exp_tc[0]));
    check("u0.at_bound", 32'(if0.at_bound), (if0.up ? (exp_out[0] == maxv[0]) : (exp_out[0] == 0)) ? 32'd1 : 32'd0);
    check("u1.out", 32'(if1.out), 32'(exp_out[1]));
    check("u1.tc",  32'(if1.tc),  32'(exp_tc[1]));
    check("u1.at_bound", 32'(if1.at_bound), (if1.up ? (exp_out[1] == maxv[1]) : (exp_out[1] == 0)) ? 32'd1 : 32'd0);
    check("u2.out", 32'(if2.out), 32'(exp_out[2]));
    check("u2.tc",  32'(if2.tc),  32'(exp_tc[2]));
    check("u2.at_bound", 32'(if2.at_bound), (if2.up ? (exp_out[2] == maxv[2]) : (exp_out[2] == 0)) ? 32'd1 : 32'd0);
  end

  task automatic edge_wait();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int up_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_seq [3]  = '{9, 8, 7};
    int u2_seq [5]  = '{255, 0, 1, 2, 3};
    int u2_tc  [5]  = '{0, 1, 0, 0, 0};

    reset = 1'b1;
    if0.en = 1'b0; if0.up = 1'b0; if0.load = 1'b0; if0.load_val = 4'd0;
    if1.en = 1'b0; if1.up = 1'b0; if1.load = 1'b0; if1.load_val = 4'd0;
    if2.en = 1'b0; if2.up = 1'b0; if2.load = 1'b0; if2.load_val = 8'd0;
    #2 reset = 1'b0;
    #10;
    check("reset out", 32'(if0.out), 32'd0);
    check("reset tc",  32'(if0.tc),  32'd0);
    reset = 1'b1;

    // Wrapping up-count: twelve edges starting from reset.
    if0.en = 1'b1; if0.up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edge_wait();
      check("wrap up out", 32'(if0.out), 32'(up_seq[i]));
      check("wrap up tc",  32'(if0.tc),  (i == 9) ? 32'd1 : 32'd0);
    end
    if0.en = 1'b0;

    // Reset from a non-zero count, then count down from 0 (wraps to 9 with a tc pulse).
    reset = 1'b0;
    #1;
    check("async reset out", 32'(if0.out), 32'd0);
    #1 reset = 1'b1;
    if0.en = 1'b1; if0.up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      check("wrap down out", 32'(if0.out), 32'(dn_seq[i]));
      check("wrap down tc",  32'(if0.tc),  (i == 0) ? 32'd1 : 32'd0);
    end
    if0.en = 1'b0;

    // Saturating up-count: stops at 9 with a single tc pulse.
    if1.en = 1'b1; if1.up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      edge_wait();
      check("sat up out", 32'(if1.out), (i < 9) ? 32'(i) : 32'd9);
      check("sat up tc",  32'(if1.tc),  (i == 9) ? 32'd1 : 32'd0);
    end
    check("sat at_bound", 32'(if1.at_bound), 32'd1);
    if1.up = 1'b0;
    for (int i = 0; i < 11; i++) edge_wait();
    check("sat down floor", 32'(if1.out), 32'd0);
    if1.en = 1'b0;

    // Clamped load with en also high, then wrap on the next edge.
    if0.load = 1'b1; if0.load_val = 4'd13; if0.en = 1'b1; if0.up = 1'b0;
    edge_wait();
    check("clamp load out", 32'(if0.out), 32'd9);
    check("clamp load tc",  32'(if0.tc),  32'd0);
    if0.load = 1'b0; if0.up = 1'b1;
    edge_wait();
    check("post load out", 32'(if0.out), 32'd0);
    check("post load tc",  32'(if0.tc),  32'd1);
    if0.load = 1'b1; if0.load_val = 4'd6;
    edge_wait();
    check("load 6", 32'(if0.out), 32'd6);
    if0.load = 1'b0; if0.en = 1'b0;
    edge_wait();
    check("hold out", 32'(if0.out), 32'd6);

    // Reset pulsed between edges while out = 6, then counting resumes.
    reset = 1'b0;
    #1;
    check("mid reset out", 32'(if0.out), 32'd0);
    check("mid reset tc",  32'(if0.tc),  32'd0);
    #1 reset = 1'b1;
    if0.en = 1'b1; if0.up = 1'b1;
    edge_wait();
    check("resume 1", 32'(if0.out), 32'd1);
    edge_wait();
    check("resume 2", 32'(if0.out), 32'd2);

    // Reset held low across an edge on which load is high: reset wins.
    if0.en = 1'b0; if0.load = 1'b1; if0.load_val = 4'd7;
    reset = 1'b0;
    edge_wait();
    check("reset vs load", 32'(if0.out), 32'd0);
    reset = 1'b1; if0.load = 1'b0;
    edge_wait();

    // 8-bit instance: up-count across 255, then a direction change at out = 3.
    if2.load = 1'b1; if2.load_val = 8'd254;
    edge_wait();
    check("u2 load", 32'(if2.out), 32'd254);
    if2.load = 1'b0; if2.en = 1'b1; if2.up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge_wait();
      check("u2 up out", 32'(if2.out), 32'(u2_seq[i]));
      check("u2 up tc",  32'(if2.tc),  32'(u2_tc[i]));
    end
    if2.up = 1'b0;
    edge_wait();
    check("u2 turn out", 32'(if2.out), 32'd2);
    check("u2 turn tc",  32'(if2.tc),  32'd0);
    edge_wait();
    edge_wait();
    edge_wait();
    check("u2 down wrap out", 32'(if2.out), 32'd255);
    check("u2 down wrap tc",  32'(if2.tc),  32'd1);
    if2.en = 1'b0;

    repeat (3) edge_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal count (modulus-1); legal range 1..2**WIDTH-1.
REQ-003 Parameter MODE, default 0: 0 = wrap-around, 1 = saturate.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 resets all state immediately, independent of clk.
REQ-006 en  input  1  count enable; 1 = advance one step on this edge.
REQ-007 up  input  1  direction; 1 = increment, 0 = decrement; sampled only when en=1.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value written on load.
REQ-010 out  output  WIDTH  registered count value.
REQ-011 tc  output  1  registered terminal-count pulse.
REQ-012 at_bound  output  1  combinational; 1 when out equals the bound in the current up direction (MAX_VAL if up=1, 0 if up=0).

Function
REQ-013 Per-edge priority SHALL be: load, then en, then hold.
REQ-014 load=1 SHALL write min(load_val, MAX_VAL) to out; en and up ignored that cycle; tc=0 on that edge.
REQ-015 Increment, en=1, up=1, out<MAX_VAL: out SHALL become out+1 next edge.
REQ-016 Decrement, en=1, up=0, out>0: out SHALL become out-1 next edge.
REQ-017 MODE=0, up=1, out==MAX_VAL, en=1: out SHALL become 0.
REQ-018 MODE=0, up=0, out==0, en=1: out SHALL become MAX_VAL.
REQ-019 MODE=1 at bound in counting direction: out SHALL hold its value; no wrap ever occurs.
REQ-020 MODE=0: tc SHALL be 1 for exactly the one cycle following an edge on which out wrapped (REQ-017/018); 0 otherwise.
REQ-021 MODE=1: tc SHALL be 1 for exactly the one cycle following an edge on which out stepped onto the bound; attempts to count past the bound SHALL NOT re-assert tc.
REQ-022 en=0 and load=0: out SHALL hold; tc SHALL be 0 next cycle.
REQ-023 Direction change mid-count SHALL take effect on the same edge up is sampled; no extra latency.
REQ-024 Out-of-range state (out>MAX_VAL) SHALL be unreachable; load values above MAX_VAL clamp per REQ-014.
REQ-025 Latency: one clock from en/load sampled to out updated; tc coincident with the out update it flags.
REQ-026 All arithmetic SHALL be WIDTH bits, unsigned; no value outside 0..MAX_VAL SHALL ever appear on out.

Reset
REQ-027 reset=0 SHALL force out=0 and tc=0 asynchronously, within the same cycle, regardless of clk, en, load.
REQ-028 Reset asserted mid-count or coincident with load SHALL win; no partial update survives.
REQ-029 After reset deasserts, first counting edge SHALL follow REQ-013..REQ-021 from out=0 (MODE=0, up=0, en=1 wraps to MAX_VAL with tc pulse).

Verification (WIDTH=4, MAX_VAL=9 unless noted)
REQ-030 MODE=0, up=1, en=1 held 12 edges from reset -> out 1..9,0,1,2; tc high only the cycle after the 9->0 edge.
REQ-031 MODE=0, up=0, en=1 from reset -> out 9,8,7...; tc high the cycle after the 0->9 edge.
REQ-032 MODE=1, up=1, en=1 held 12 edges -> out stops at 9; tc single pulse on 8->9; stays 0 thereafter; at_bound=1.
REQ-033 load=1, load_val=13, en=1 same edge -> out=9 (clamped), tc=0; next edge en=1, up=1, MODE=0 -> out=0, tc=1.
REQ-034 reset pulsed low between clk edges while out=6 -> out=0, tc=0 immediately; count resumes 1,2 after release.
REQ-035 WIDTH=8, MAX_VAL=255, MODE=0: up-count across 255 -> out 254,255,0; tc pulse on 255->0; toggle up at out=3 -> next out=2.
